// File: rtl/layer_serializer_if.sv
// Serial output stream of layer_serializer: one word per accepted valid/ready handshake.
`default_nettype none

interface layer_serializer_if #(
  parameter int dataWidth = 16
);
  logic [dataWidth-1:0] data_out;
  logic                 data_valid;
  logic                 data_ready;
  logic                 data_last;

  modport master (
    output data_out,
    output data_valid,
    output data_last,
    input  data_ready
  );

  modport slave (
    input  data_out,
    input  data_valid,
    input  data_last,
    output data_ready
  );
endinterface

`default_nettype wire

// File: rtl/layer_serializer.sv
// =============================================================================
// layer_serializer: collects one output per neuron of a layer, then streams
// them in neuron order over a valid/ready interface.  Rev 1.0
// =============================================================================
`default_nettype none

module layer_serializer #(
  parameter int numNeuron = 30,
  parameter int dataWidth = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [numNeuron*dataWidth-1:0] neuron_out,
  input  logic [numNeuron-1:0]           neuron_valid,
  layer_serializer_if.master             out_if,
  output logic                           busy,
  output logic                           overrun
);

  localparam int IDX_W = (numNeuron > 1) ? $clog2(numNeuron) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(numNeuron - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_SEND    = 2'd2;

  logic [1:0]           state_q,   state_d;
  logic [IDX_W-1:0]     idx_q,     idx_d;
  logic [numNeuron-1:0] mask_q,    mask_d;
  logic                 overrun_q, overrun_d;
  logic [dataWidth-1:0] buf_q [numNeuron];

  logic sending;
  logic accept;
  logic capture_en;

  assign sending    = (state_q == S_SEND);
  assign capture_en = (state_q == S_IDLE) || (state_q == S_COLLECT);
  assign accept     = sending && out_if.data_ready;

  // Outputs decode directly from registers so reset clears them immediately.
  assign out_if.data_valid = sending;
  assign out_if.data_out   = sending ? buf_q[idx_q] : '0;
  assign out_if.data_last  = sending && (idx_q == LAST_IDX);
  assign busy              = (state_q != S_IDLE);
  assign overrun           = overrun_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    mask_d    = mask_q;
    overrun_d = overrun_q;
    case (state_q)
      S_IDLE, S_COLLECT: begin
        mask_d = mask_q | neuron_valid;
        if (&mask_d) begin
          state_d = S_SEND;
        end else if (|neuron_valid) begin
          state_d = S_COLLECT;
        end
      end
      S_SEND: begin
        if (|neuron_valid) begin
          overrun_d = 1'b1;
        end
        if (accept) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            mask_d  = '0;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
        mask_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      mask_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      mask_q    <= mask_d;
      overrun_q <= overrun_d;
    end
  end

  // Buffer needs no reset: an entry is only read after it has been captured.
  always_ff @(posedge clk) begin
    for (int i = 0; i < numNeuron; i++) begin
      if (capture_en && neuron_valid[i]) begin
        buf_q[i] <= neuron_out[i*dataWidth +: dataWidth];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_layer_serializer.sv
// Directed self-checking bench for layer_serializer (numNeuron=4, dataWidth=16).
`default_nettype none

module tb_layer_serializer;

  logic        clk;
  logic        rst;
  logic [63:0] nout;
  logic [3:0]  nval;
  logic        busy;
  logic        overrun;
  int          n_cmp;
  int          n_err;

  layer_serializer_if #(.dataWidth(16)) s_if ();

  layer_serializer #(.numNeuron(4), .dataWidth(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .neuron_out   (nout),
    .neuron_valid (nval),
    .out_if       (s_if.master),
    .busy         (busy),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    rst = 1'b0; nout = '0; nval = '0; s_if.data_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (s_if.data_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 ||
        s_if.data_out !== 16'h0 || s_if.data_last !== 1'b0) begin
      $display("FAIL reset_held: got valid=%b busy=%b ovr=%b data=%h last=%b, want all 0",
               s_if.data_valid, busy, overrun, s_if.data_out, s_if.data_last);
      n_err++;
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (s_if.data_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
      $display("FAIL reset_release: got valid=%b busy=%b ovr=%b, want 0 0 0",
               s_if.data_valid, busy, overrun);
      n_err++;
    end
  endtask

  task automatic test_all_at_once;
    nout = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    nval = 4'hF; s_if.data_ready = 1'b1;
    @(negedge clk);
    nval = '0;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (s_if.data_valid !== 1'b1 || s_if.data_out !== 16'(k + 1) ||
          s_if.data_last !== (k == 3) || busy !== 1'b1) begin
        $display("FAIL all_word%0d: got valid=%b data=%h last=%b busy=%b, want 1 %h %b 1",
                 k, s_if.data_valid, s_if.data_out, s_if.data_last, busy, 16'(k + 1), (k == 3));
        n_err++;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (s_if.data_valid !== 1'b0 || busy !== 1'b0 || s_if.data_out !== 16'h0) begin
      $display("FAIL all_idle: got valid=%b busy=%b data=%h, want 0 0 0000",
               s_if.data_valid, busy, s_if.data_out);
      n_err++;
    end
  endtask

  task automatic test_skewed;
    logic [15:0] exp [4];
    exp = '{16'hA000, 16'hA111, 16'hA222, 16'hA333};
    nout = {exp[3], exp[2], exp[1], exp[0]};
    s_if.data_ready = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      nval = (c == 0) ? 4'b0001 : (c == 3) ? 4'b0100 : (c == 5) ? 4'b1010 : 4'b0000;
      @(negedge clk);
      nval = '0;
      n_cmp++;
      if (busy !== 1'b1 || s_if.data_valid !== (c == 5)) begin
        $display("FAIL skew_cycle%0d: got busy=%b valid=%b, want 1 %b",
                 c + 1, busy, s_if.data_valid, (c == 5));
        n_err++;
      end
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (s_if.data_valid !== 1'b1 || s_if.data_out !== exp[k] || s_if.data_last !== (k == 3)) begin
        $display("FAIL skew_word%0d: got valid=%b data=%h last=%b, want 1 %h %b",
                 k, s_if.data_valid, s_if.data_out, s_if.data_last, exp[k], (k == 3));
        n_err++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] exp [4];
    exp = '{16'h1234, 16'hBEEF, 16'h5678, 16'h9ABC};
    nout = {exp[3], exp[2], exp[1], exp[0]};
    nval = 4'hF; s_if.data_ready = 1'b1;
    @(negedge clk);
    nval = '0;
    n_cmp++;
    if (s_if.data_out !== exp[0] || s_if.data_valid !== 1'b1) begin
      $display("FAIL bp_word0: got data=%h valid=%b, want %h 1", s_if.data_out, s_if.data_valid, exp[0]);
      n_err++;
    end
    @(negedge clk);
    s_if.data_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_cmp++;
      if (s_if.data_out !== 16'hBEEF || s_if.data_valid !== 1'b1 || s_if.data_last !== 1'b0) begin
        $display("FAIL bp_hold%0d: got data=%h valid=%b last=%b, want beef 1 0",
                 c, s_if.data_out, s_if.data_valid, s_if.data_last);
        n_err++;
      end
      @(negedge clk);
    end
    s_if.data_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      n_cmp++;
      if (s_if.data_out !== exp[k] || s_if.data_valid !== 1'b1 || s_if.data_last !== (k == 3)) begin
        $display("FAIL bp_word%0d: got data=%h valid=%b last=%b, want %h 1 %b",
                 k, s_if.data_out, s_if.data_valid, s_if.data_last, exp[k], (k == 3));
        n_err++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_repeat;
    logic [15:0] exp [4];
    exp = '{16'h0A0A, 16'h0B0B, 16'h2222, 16'h0D0D};
    s_if.data_ready = 1'b1;
    nout = {16'h0D0D, 16'h1111, 16'h0B0B, 16'h0A0A};
    nval = 4'b0100;
    @(negedge clk);
    nout = {16'h0D0D, 16'h2222, 16'h0B0B, 16'h0A0A};
    @(negedge clk);
    nval = 4'b1011;
    @(negedge clk);
    nval = '0;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (s_if.data_out !== exp[k] || s_if.data_valid !== 1'b1 || overrun !== 1'b0) begin
        $display("FAIL rep_word%0d: got data=%h valid=%b ovr=%b, want %h 1 0",
                 k, s_if.data_out, s_if.data_valid, overrun, exp[k]);
        n_err++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_overrun;
    logic [15:0] exp [4];
    exp = '{16'h7001, 16'h7002, 16'h7003, 16'h7004};
    nout = {exp[3], exp[2], exp[1], exp[0]};
    nval = 4'hF; s_if.data_ready = 1'b0;
    @(negedge clk);
    nout = {exp[3], exp[2], exp[1], 16'hFFFF};
    nval = 4'b0001;
    @(negedge clk);
    nval = '0;
    n_cmp++;
    if (overrun !== 1'b1 || s_if.data_out !== exp[0] || s_if.data_valid !== 1'b1) begin
      $display("FAIL ovr_set: got ovr=%b data=%h valid=%b, want 1 %h 1",
               overrun, s_if.data_out, s_if.data_valid, exp[0]);
      n_err++;
    end
    s_if.data_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (s_if.data_out !== exp[k] || s_if.data_valid !== 1'b1 || overrun !== 1'b1) begin
        $display("FAIL ovr_word%0d: got data=%h valid=%b ovr=%b, want %h 1 1",
                 k, s_if.data_out, s_if.data_valid, overrun, exp[k]);
        n_err++;
      end
      @(negedge clk);
    end
    nout = {16'h8004, 16'h8003, 16'h8002, 16'h8001};
    nval = 4'hF;
    @(negedge clk);
    nval = '0;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (s_if.data_out !== 16'(16'h8001 + k) || s_if.data_last !== (k == 3) || overrun !== 1'b1) begin
        $display("FAIL ovr_next%0d: got data=%h last=%b ovr=%b, want %h %b 1",
                 k, s_if.data_out, s_if.data_last, overrun, 16'(16'h8001 + k), (k == 3));
        n_err++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset;
    nout = {16'hD004, 16'hD003, 16'hD002, 16'hD001};
    nval = 4'hF; s_if.data_ready = 1'b1;
    @(negedge clk);
    nval = '0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (s_if.data_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 || s_if.data_out !== 16'h0) begin
      $display("FAIL arst_drop: got valid=%b busy=%b ovr=%b data=%h, want 0 0 0 0000",
               s_if.data_valid, busy, overrun, s_if.data_out);
      n_err++;
    end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++;
      if (s_if.data_valid !== 1'b0 || busy !== 1'b0) begin
        $display("FAIL arst_idle%0d: got valid=%b busy=%b, want 0 0", c, s_if.data_valid, busy);
        n_err++;
      end
    end
    nout = {16'hE004, 16'hE003, 16'hE002, 16'hE001};
    nval = 4'b0011;
    @(negedge clk);
    nval = '0;
    n_cmp++;
    if (s_if.data_valid !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL arst_partial: got valid=%b busy=%b, want 0 1", s_if.data_valid, busy);
      n_err++;
    end
    nval = 4'b1100;
    @(negedge clk);
    nval = '0;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (s_if.data_out !== 16'(16'hE001 + k) || s_if.data_valid !== 1'b1 || s_if.data_last !== (k == 3)) begin
        $display("FAIL arst_word%0d: got data=%h valid=%b last=%b, want %h 1 %b",
                 k, s_if.data_out, s_if.data_valid, s_if.data_last, 16'(16'hE001 + k), (k == 3));
        n_err++;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_all_at_once();
    test_skewed();
    test_backpressure();
    test_repeat();
    test_overrun();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/layer_serializer.md
LAYER_SERIALIZER -- requirements
Module: layer_serializer

Interface
REQ-001 SHALL have parameter numNeuron, default 30, number of neuron outputs collected from one layer.
REQ-002 SHALL have parameter dataWidth, default 16, width of one neuron output and of the serial output word.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port neuron_out  input  numNeuron*dataWidth  packed neuron outputs; neuron i occupies bits [i*dataWidth +: dataWidth].
REQ-006 SHALL have port neuron_valid  input  numNeuron  per-neuron outvalid pulses; bit i qualifies slice i.
REQ-007 SHALL have port data_out  output  dataWidth  serial word driving the next layer's myinput.
REQ-008 SHALL have port data_valid  output  1  qualifies data_out; drives the next layer's myinputValid.
REQ-009 SHALL have port data_ready  input  1  consumer accepts data_out when data_valid and data_ready are both high on a rising edge.
REQ-010 SHALL have port data_last  output  1  high with data_valid on the word from neuron numNeuron-1.
REQ-011 SHALL have port busy  output  1  high in COLLECT or SEND.
REQ-012 SHALL have port overrun  output  1  sticky error flag.

Function
REQ-013 SHALL implement states IDLE, COLLECT and SEND.
REQ-014 In IDLE or COLLECT, on each edge, SHALL store slice i into buffer entry i and set captured bit i for every i with neuron_valid[i] high; any number of bits may be high in one cycle.
REQ-015 A repeated valid for an already-captured neuron in COLLECT SHALL overwrite that entry and SHALL NOT set overrun.
REQ-016 IDLE SHALL go to COLLECT on any neuron_valid bit unless that same edge completes the mask.
REQ-017 When the captured mask, including the current cycle's captures, becomes all ones, the state SHALL go to SEND on that edge, from IDLE or COLLECT.
REQ-018 Latency SHALL be one cycle: the last capture on edge T gives data_valid high with entry 0 after edge T.
REQ-019 In SEND, data_out SHALL equal buffer[idx] and data_valid SHALL be high; idx starts at 0.
REQ-020 On each accepted handshake idx SHALL increment by 1.
REQ-021 data_out and data_valid SHALL hold stable while data_ready is low.
REQ-022 data_last SHALL equal data_valid AND (idx == numNeuron-1).
REQ-023 The accepted handshake with data_last high SHALL clear idx and the captured mask and return the state to IDLE; data_valid SHALL be low on the next cycle.
REQ-024 Any neuron_valid bit high in SEND, including the final-handshake cycle, SHALL be ignored and SHALL set overrun.
REQ-025 overrun SHALL clear only on reset.
REQ-026 data_valid SHALL be low in IDLE and COLLECT; data_out SHALL be 0 when data_valid is low.
REQ-027 idx SHALL be $clog2(numNeuron) bits wide with a minimum of 1 bit, and SHALL never exceed numNeuron-1.
REQ-028 Data SHALL pass through bit-exact: no sign extension, truncation or arithmetic.
REQ-029 For numNeuron == 1, the single capture SHALL go to SEND, and the one word SHALL carry data_last.

Reset
REQ-030 Reset low SHALL immediately force the state to IDLE, idx to 0, the captured mask to 0, and data_valid, data_last, busy, overrun and data_out to 0.
REQ-031 Buffer contents need not be cleared and SHALL be unobservable until recaptured.
REQ-032 Reset asserted mid-COLLECT or mid-SEND SHALL abort the transfer; after release the block SHALL wait in IDLE for a full new set of captures.
REQ-033 Deassertion SHALL take effect at the first rising clk edge after rst goes high, without glitching the outputs.

Verification (bench numNeuron=4, dataWidth=16)
REQ-034 All four valids in one cycle with values 0x0001, 0x0002, 0x0003, 0x0004 and data_ready held high -> next 4 cycles show data_out 1, 2, 3, 4 with data_valid high; data_last on the 4th word only; then IDLE with busy low.
REQ-035 Skewed valids (bit0 at cycle 0, bit2 at cycle 3, bits 1 and 3 at cycle 5) -> busy high from cycle 1; first data_valid the cycle after cycle 5; word order 0 to 3.
REQ-036 data_ready low for 3 cycles on word 1 (value 0xBEEF) -> data_out holds 0xBEEF with data_valid high for 3 cycles; idx does not advance; remaining words follow in order.
REQ-037 neuron_valid=4'b0001 during SEND -> overrun goes high and stays high; streamed data is unchanged; a following collection completes normally with overrun still high.
REQ-038 Repeated valid on neuron 2 (0x1111, then 0x2222) before completion -> streamed word 2 is 0x2222; overrun stays 0.
REQ-039 rst low asynchronously mid-SEND after word 1 -> data_valid and busy drop before the next clk edge; after release, no output until all 4 neurons are captured again.
